serial_transmitter: RTL and testbench
=====================================

Name: serial_transmitter

Overview:
Parallel-to-serial driver for the serial configuration interface. It accepts a DATA_LEN-bit word over a valid/ready handshake and shifts the word out MSB-first on ser_data, qualified by ser_enable. It then pulses ser_update so the downstream shift_register latches its parallel bit_out. It sits on the host side and drives shift_register's data_in, enable and update pins directly.

Parameters:
DATA_LEN, `DATA_LEN (from includes.svh), word width and number of bits shifted per transfer; must be ≥ 2.
BIT_CYCLES, 1, clock cycles per serial bit; must be ≥ 1.
UPDATE_CYCLES, 1, width in cycles of the ser_update pulse; must be ≥ 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-low reset.
word_in  input  DATA_LEN  parallel word to transmit; sampled on handshake.
word_valid  input  1  word_in is valid.
word_ready  output  1  transmitter can accept a word.
ser_data  output  1  serial data, connects to shift_register data_in.
ser_enable  output  1  shift strobe, connects to shift_register enable.
ser_update  output  1  latch strobe, connects to shift_register update.
busy  output  1  transfer in progress (not IDLE).
done  output  1  one-cycle pulse after the update phase ends.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, word_ready=1, ser_data=0, ser_enable=0, ser_update=0, busy=0, done=0, internal shift register and counters are cleared. Reset mid-transfer aborts the transfer with no update pulse.
- All outputs are registered. word_ready is high only in IDLE.
- States:
  - IDLE: on word_valid && word_ready at edge k, load word_in and go to SHIFT.
  - SHIFT: lasts DATA_LEN*BIT_CYCLES cycles, starting at cycle k+1.
  - UPDATE: lasts UPDATE_CYCLES cycles.
  - After UPDATE, return to IDLE.
- SHIFT detail:
  - Bit i (i = 0..DATA_LEN-1) carries word[DATA_LEN-1-i], MSB first.
  - ser_data holds that bit for BIT_CYCLES cycles.
  - ser_enable is high only in the last cycle of each bit period. With BIT_CYCLES=1, ser_enable is high continuously for DATA_LEN cycles.
  - Result: the first bit sent ends in shift_register bit_out[DATA_LEN-1].
- UPDATE detail: ser_update=1, ser_enable=0, ser_data=0.
- Exit from UPDATE: done=1 for exactly one cycle, in the first IDLE cycle, with word_ready=1 in the same cycle.
- Latency: the first IDLE cycle is k + DATA_LEN*BIT_CYCLES + UPDATE_CYCLES + 1. A new word may be accepted on that edge, so back-to-back transfers have a one-cycle IDLE gap.
- word_in and word_valid changes during SHIFT or UPDATE are ignored; the loaded word is immutable.
- Counters:
  - Bit counter width is $clog2(DATA_LEN); it must terminate exactly at DATA_LEN-1, with no wrap to 0 mid-transfer.
  - Cycle counter width is $clog2(max(BIT_CYCLES, UPDATE_CYCLES)+1).
- ser_enable and ser_update are never high in the same cycle.
- busy=1 exactly when the state is SHIFT or UPDATE.

Decomposition:
- Package serial_if_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} ser_tx_state_t;
  - DATA_LEN-derived localparams for counter widths.
- Optional sub-module serial_bit_timer: a BIT_CYCLES down-counter producing a bit_tick strobe, cleared by a load input and by reset. The FSM and the shift register stay in serial_transmitter.

Test Plan:
1. Reset then idle (DATA_LEN=8, BIT_CYCLES=1): hold reset=0 for 10 ns, release → word_ready=1, ser_* all 0, busy=0; no activity while word_valid=0.
2. Single transfer of 8'hA5: handshake at edge k → ser_data sequence 1,0,1,0,0,1,0,1 on cycles k+1..k+8 with ser_enable=1. Then ser_update=1 at k+9 and done=1 at k+10. A connected shift_register shows bit_out=8'hA5.
3. BIT_CYCLES=3, word 8'h81: each bit is held 3 cycles and ser_enable pulses on every third cycle (8 pulses total). ser_update appears at k+25, and shift_register bit_out=8'h81.
4. Back-to-back 8'hFF then 8'h00 with word_valid held high: second handshake occurs on the done cycle, and the second transfer yields bit_out=8'h00. word_in changed mid-transfer does not alter the first word.
5. Reset asserted at cycle k+4 of a transfer: outputs go to 0 immediately (asynchronously), and no ser_update occurs. After release, word_ready=1 and a fresh 8'h3C transfers correctly.
6. UPDATE_CYCLES=2, word 8'h01: ser_update is high for exactly 2 cycles, and ser_enable is never high in the same cycle as ser_update (checked by assertion throughout all tests).

Source files
------------

// File: rtl/serial_if_pkg.sv
// Shared types and sizing helpers for the serial configuration interface.
// Holds the transmitter state enum and counter-width helpers.
package serial_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } ser_tx_state_t;

  localparam int DEF_DATA_LEN = 8;

  function automatic int cyc_cnt_w(
    input int bit_cycles,
    input int update_cycles
  );
    int m;
    m = (bit_cycles > update_cycles) ? bit_cycles : update_cycles;
    return $clog2(m + 1);
  endfunction

  localparam int DEF_BIT_CNT_W = $clog2(DEF_DATA_LEN);
  localparam int DEF_CYC_CNT_W = cyc_cnt_w(1, 1);

endpackage

// File: rtl/serial_transmitter.sv
// Parallel-to-serial driver: shifts a word out MSB-first, then pulses update.
// Ports: clk, reset (async, active low), word_in/word_valid/word_ready
// handshake, ser_data/ser_enable/ser_update to shift_register, busy, done.
module serial_transmitter
  import serial_if_pkg::*;
#(
  parameter int DATA_LEN      = DEF_DATA_LEN,
  parameter int BIT_CYCLES    = 1,
  parameter int UPDATE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] word_in,
  input  logic                word_valid,
  output logic                word_ready,
  output logic                ser_data,
  output logic                ser_enable,
  output logic                ser_update,
  output logic                busy,
  output logic                done
);

  localparam int BW = $clog2(DATA_LEN);
  localparam int CW = cyc_cnt_w(BIT_CYCLES, UPDATE_CYCLES);

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_LEN - 1);
  localparam logic [CW-1:0] BC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] UC_LAST  = CW'(UPDATE_CYCLES - 1);
  localparam logic          EN_EVERY = (BIT_CYCLES == 1);

  ser_tx_state_t       state_q, state_d;
  logic [DATA_LEN-1:0] sr_q, sr_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic                ready_q, ready_d;
  logic                en_q, en_d;
  logic                upd_q, upd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // The shift register is zero outside SHIFT, so its MSB
  // is directly the registered serial data line.
  assign ser_data   = sr_q[DATA_LEN-1];
  assign word_ready = ready_q;
  assign ser_enable = en_q;
  assign ser_update = upd_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    ready_d = 1'b0;
    en_d    = 1'b0;
    upd_d   = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (word_valid && ready_q) begin
          state_d = SHIFT;
          sr_d    = word_in;
          bit_d   = '0;
          cyc_d   = BC_LAST;
          en_d    = EN_EVERY;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (cyc_q == '0) begin
          if (bit_q == BIT_LAST) begin
            state_d = UPDATE;
            sr_d    = '0;
            cyc_d   = UC_LAST;
            upd_d   = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            sr_d  = {sr_q[DATA_LEN-2:0], 1'b0};
            cyc_d = BC_LAST;
            en_d  = EN_EVERY;
          end
        end else begin
          cyc_d = cyc_q - CW'(1);
          // Strobe lands on the last cycle of the bit period.
          en_d  = (cyc_q == CW'(1));
        end
      end
      UPDATE: begin
        if (cyc_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q - CW'(1);
          upd_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter with a behavioural shift_register.
// Three instances cover BIT_CYCLES=1/3 and UPDATE_CYCLES=1/2.
module tb_serial_transmitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] wA = '0, wB = '0, wC = '0;
  logic vA = 1'b0, vB = 1'b0, vC = 1'b0;
  logic rA, dA, eA, uA, bA, oA;
  logic rB, dB, eB, uB, bB, oB;
  logic rC, dC, eC, uC, bC, oC;

  serial_transmitter #(.DATA_LEN(8), .BIT_CYCLES(1), .UPDATE_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst_n), .word_in(wA), .word_valid(vA),
    .word_ready(rA), .ser_data(dA), .ser_enable(eA),
    .ser_update(uA), .busy(bA), .done(oA));

  serial_transmitter #(.DATA_LEN(8), .BIT_CYCLES(3), .UPDATE_CYCLES(1)) dut_b (
    .clk(clk), .reset(rst_n), .word_in(wB), .word_valid(vB),
    .word_ready(rB), .ser_data(dB), .ser_enable(eB),
    .ser_update(uB), .busy(bB), .done(oB));

  serial_transmitter #(.DATA_LEN(8), .BIT_CYCLES(1), .UPDATE_CYCLES(2)) dut_c (
    .clk(clk), .reset(rst_n), .word_in(wC), .word_valid(vC),
    .word_ready(rC), .ser_data(dC), .ser_enable(eC),
    .ser_update(uC), .busy(bC), .done(oC));

  // Behavioural downstream shift_register per instance
  logic [7:0]  srA = '0, srB = '0, srC = '0;
  logic [7:0]  boA = '0, boB = '0, boC = '0;
  logic [15:0] updA_n = '0;

  always_ff @(posedge clk) begin
    if (eA) srA <= {srA[6:0], dA};
    if (uA) boA <= srA;
    if (uA) updA_n <= updA_n + 16'd1;
    if (eB) srB <= {srB[6:0], dB};
    if (uB) boB <= srB;
    if (eC) srC <= {srC[6:0], dC};
    if (uC) boC <= srC;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (!((eA && uA) || (eB && uB) || (eC && uC))) else begin
        fails++;
        $error("FAIL en_upd_overlap: observed A=%b%b B=%b%b C=%b%b required no overlap",
               eA, uA, eB, uB, eC, uC);
      end
    end
  end

  function automatic logic [3:0] va();
    return {dA, eA, uA, bA};
  endfunction
  function automatic logic [3:0] vb();
    return {dB, eB, uB, bB};
  endfunction
  function automatic logic [3:0] vc();
    return {dC, eC, uC, bC};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  w;
  logic [15:0] n0;

  initial begin
    // 1: reset and idle
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vec", 16'(va()), 16'h0);
    chk("rst_ready_done", {14'd0, rA, oA}, 16'b10);
    chk("rst_ready_bc", {14'd0, rB, rC}, 16'b11);
    repeat (3) @(negedge clk);
    chk("idle_vec", 16'(va()), 16'h0);
    chk("idle_ready", {15'd0, rA}, 16'd1);

    // 2: single transfer A5
    w = 8'hA5; wA = w; vA = 1'b1;
    @(negedge clk);
    vA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_bit%0d", i), 16'(va()), 16'({w[7-i], 3'b101}));
      @(negedge clk);
    end
    chk("a5_update", {12'd0, va()}, 16'b0011);
    chk("a5_ready_upd", {15'd0, rA}, 16'd0);
    @(negedge clk);
    chk("a5_done", {12'd0, oA, rA, bA, uA}, 16'b1100);
    chk("a5_bitout", {8'd0, boA}, 16'hA5);
    @(negedge clk);
    chk("a5_done_clr", {15'd0, oA}, 16'd0);

    // 3: BIT_CYCLES=3, word 81
    w = 8'h81; wB = w; vB = 1'b1;
    @(negedge clk);
    vB = 1'b0;
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("b81_cyc%0d", c), 16'(vb()),
          16'({w[7-c/3], (c % 3 == 2), 2'b01}));
      @(negedge clk);
    end
    chk("b81_update", 16'(vb()), 16'b0011);
    @(negedge clk);
    chk("b81_done", {14'd0, oB, rB}, 16'b11);
    chk("b81_bitout", {8'd0, boB}, 16'h81);

    // 4: back-to-back FF then 00, valid held high
    @(negedge clk);
    wA = 8'hFF; vA = 1'b1;
    @(negedge clk);
    wA = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ff_bit%0d", i), 16'(va()), 16'b1101);
      @(negedge clk);
    end
    chk("ff_update", 16'(va()), 16'b0011);
    @(negedge clk);
    chk("ff_done_ready", {14'd0, oA, rA}, 16'b11);
    chk("ff_bitout", {8'd0, boA}, 16'hFF);
    @(negedge clk);
    vA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("z_bit%0d", i), 16'(va()), 16'b0101);
      @(negedge clk);
    end
    chk("z_update", 16'(va()), 16'b0011);
    @(negedge clk);
    chk("z_done", {15'd0, oA}, 16'd1);
    chk("z_bitout", {8'd0, boA}, 16'h00);

    // 5: async reset mid-transfer, then 3C
    @(negedge clk);
    wA = 8'h5A; vA = 1'b1;
    @(negedge clk);
    vA = 1'b0;
    repeat (3) @(negedge clk);
    n0 = updA_n;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", 16'(va()), 16'h0);
    chk("arst_ready_done", {14'd0, rA, oA}, 16'b10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_update", updA_n, n0);
    chk("arst_bitout_kept", {8'd0, boA}, 16'h00);
    chk("arst_idle", {11'd0, rA, va()}, 16'b10000);
    w = 8'h3C; wA = w; vA = 1'b1;
    @(negedge clk);
    vA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("3c_bit%0d", i), 16'(va()), 16'({w[7-i], 3'b101}));
      @(negedge clk);
    end
    chk("3c_update", 16'(va()), 16'b0011);
    @(negedge clk);
    chk("3c_bitout", {8'd0, boA}, 16'h3C);

    // 6: UPDATE_CYCLES=2, word 01
    w = 8'h01; wC = w; vC = 1'b1;
    @(negedge clk);
    vC = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("c01_bit%0d", i), 16'(vc()), 16'({w[7-i], 3'b101}));
      @(negedge clk);
    end
    chk("c01_update0", 16'(vc()), 16'b0011);
    @(negedge clk);
    chk("c01_update1", 16'(vc()), 16'b0011);
    @(negedge clk);
    chk("c01_done", {13'd0, oC, uC, eC}, 16'b100);
    chk("c01_bitout", {8'd0, boC}, 16'h01);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
